// File: rtl/ram_w16b8_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_w16b8_ctrl
// Purpose  : Request sequencer in front of a 16x8 synchronous RAM. Accepts
//            single write, single read and burst-read commands on a
//            valid/ready port. It drives registered RAM strobes and returns
//            read data as one-cycle rsp_valid pulses, so upstream logic never
//            sees the RAM select encoding, read latency or Hi-Z output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state updates on posedge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   command present
//   req_ready  out  controller can accept (state is IDLE)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   start address
//   req_wdata  in   write data (ignored for reads)
//   req_cnt    in   read beats minus 1 (ignored for writes)
//   rsp_valid  out  read data valid, one-cycle pulse per beat
//   rsp_data   out  read data, held until the next beat
//   rsp_last   out  final beat of a read, qualified by rsp_valid
//   busy       out  ~req_ready
//   mem_rw     out  RAM RW (1 = write, 0 = read)
//   mem_cs     out  RAM CS; all 1s = select, all 0s = idle
//   mem_addr   out  RAM Address
//   mem_wdata  out  RAM Data_In
//   mem_rdata  in   RAM Data_Out; only sampled in CAPT
// Configuration macro
//   RAM_INIT_SWEEP_EN : after reset, write INIT_VALUE to every location
//                       (one per cycle) before accepting commands.
// ============================================================================
module ram_w16b8_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int CS_W   = 4
`ifdef RAM_INIT_SWEEP_EN
   ,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [ADDR_W-1:0] req_cnt,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              busy,
   output logic              mem_rw,
   output logic [CS_W-1:0]   mem_cs,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_CAPT   = 2'd2,
      S_INIT   = 2'd3
   } state_t;

   localparam logic [CS_W-1:0]   C_CS_SEL  = {CS_W{1'b1}};
   localparam logic [CS_W-1:0]   C_CS_IDLE = {CS_W{1'b0}};
   localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] C_ADDR_MAX = {ADDR_W{1'b1}};

   state_t            r_state;
   state_t            w_next;
   logic              r_write;   // latched command type
   logic [ADDR_W-1:0] r_rem;     // beats remaining after the current one
   logic              w_accept;

`ifdef RAM_INIT_SWEEP_EN
   logic [ADDR_W-1:0] r_init_cnt;
`endif

   assign req_ready = (r_state == S_IDLE);
   assign busy      = ~req_ready;
   assign w_accept  = req_valid && req_ready;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef RAM_INIT_SWEEP_EN
         r_state <= S_INIT;
`else
         r_state <= S_IDLE;
`endif
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_ACCESS;
         S_ACCESS: w_next = r_write ? S_IDLE : S_CAPT;
         S_CAPT:   w_next = (r_rem == '0) ? S_IDLE : S_ACCESS;
`ifdef RAM_INIT_SWEEP_EN
         S_INIT:   if (r_init_cnt == C_ADDR_MAX) w_next = S_IDLE;
`endif
         default:  w_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   // All RAM strobes are registered: the value loaded at an edge is what the
   // RAM samples at the following edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_cs    <= C_CS_IDLE;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
         r_write   <= 1'b0;
         r_rem     <= '0;
`ifdef RAM_INIT_SWEEP_EN
         r_init_cnt <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         rsp_last  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  mem_cs    <= C_CS_SEL;
                  mem_rw    <= req_write;
                  mem_addr  <= req_addr;
                  mem_wdata <= req_wdata;
                  r_write   <= req_write;
                  r_rem     <= req_cnt;
               end else begin
                  mem_cs <= C_CS_IDLE;
               end
            end
            S_ACCESS: begin
               mem_cs <= C_CS_IDLE;
            end
            S_CAPT: begin
               // RAM data launched by the ACCESS edge is stable in this cycle.
               rsp_valid <= 1'b1;
               rsp_data  <= mem_rdata;
               rsp_last  <= (r_rem == '0);
               if (r_rem != '0) begin
                  mem_cs   <= C_CS_SEL;
                  mem_rw   <= 1'b0;
                  mem_addr <= mem_addr + C_ADDR_ONE;  // wraps modulo 2^ADDR_W
                  r_rem    <= r_rem - C_ADDR_ONE;
               end
            end
`ifdef RAM_INIT_SWEEP_EN
            S_INIT: begin
               mem_cs     <= C_CS_SEL;
               mem_rw     <= 1'b1;
               mem_addr   <= r_init_cnt;
               mem_wdata  <= INIT_VALUE;
               r_init_cnt <= r_init_cnt + C_ADDR_ONE;
            end
`endif
            default: begin
               mem_cs <= C_CS_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
